// File: rtl/xadc_monitor_sampler.sv
// rtl/xadc_monitor_sampler.sv - XADC DRP poller for Vin/Vout with over-voltage flag; XADC_AVG_EN enables 4-round averaging
module xadc_monitor_sampler #(
  parameter logic [6:0]  VIN_ADDR  = 7'h13,
  parameter logic [6:0]  VOUT_ADDR = 7'h1B,
  parameter int unsigned POLL_DIV  = 1000,
  parameter logic [11:0] OV_LIMIT  = 12'd460
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        drp_den,
  output logic [6:0]  drp_daddr,
  output logic        drp_dwe,
  input  logic        drp_drdy,
  input  logic [15:0] drp_do,
  output logic [11:0] vin_adc,
  output logic [11:0] vout_adc,
  output logic        sample_valid,
  output logic        vout_ov,
  output logic        drp_timeout
);

  localparam logic [15:0] POLL_LAST = 16'(POLL_DIV - 1);
  // The den cycle counts as 1, so the count reaches 255 in the last cycle a drdy may still land.
  localparam logic [7:0]  TMO_LAST  = 8'd255;

  typedef enum logic [2:0] {
    WAIT      = 3'd0,
    REQ_VIN   = 3'd1,
    WAIT_VIN  = 3'd2,
    REQ_VOUT  = 3'd3,
    WAIT_VOUT = 3'd4,
    UPDATE    = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] poll_q, poll_d;
  logic [7:0]  tmo_q, tmo_d;
  logic        den_q, den_d;
  logic [6:0]  daddr_q, daddr_d;
  logic [11:0] vin_raw_q, vin_raw_d;
  logic [11:0] vout_raw_q, vout_raw_d;
  logic [11:0] vin_q, vin_d;
  logic [11:0] vout_q, vout_d;
  logic        valid_q, valid_d;
  logic        ov_q, ov_d;
  logic        tflag_q, tflag_d;
`ifdef XADC_AVG_EN
  logic [13:0] vin_sum_q, vin_sum_d;
  logic [13:0] vout_sum_q, vout_sum_d;
  logic [1:0]  rnd_q, rnd_d;
  logic [13:0] vin_acc, vout_acc;
`endif

  // Next-state and datapath decode; den is registered so it is a clean single-cycle pulse.
  always_comb begin
    state_d    = state_q;
    poll_d     = poll_q;
    tmo_d      = tmo_q;
    den_d      = 1'b0;
    daddr_d    = daddr_q;
    vin_raw_d  = vin_raw_q;
    vout_raw_d = vout_raw_q;
    vin_d      = vin_q;
    vout_d     = vout_q;
    valid_d    = 1'b0;
    ov_d       = ov_q;
    tflag_d    = tflag_q;
`ifdef XADC_AVG_EN
    vin_sum_d  = vin_sum_q;
    vout_sum_d = vout_sum_q;
    rnd_d      = rnd_q;
    vin_acc    = vin_sum_q + {2'b00, vin_raw_q};
    vout_acc   = vout_sum_q + {2'b00, vout_raw_q};
`endif

    case (state_q)
      WAIT: begin
        if (poll_q == POLL_LAST) begin
          poll_d  = 16'd0;
          state_d = REQ_VIN;
        end else begin
          poll_d = poll_q + 16'd1;
        end
      end

      REQ_VIN: begin
        den_d   = 1'b1;
        daddr_d = VIN_ADDR;
        tmo_d   = 8'd1;
        state_d = WAIT_VIN;
      end

      WAIT_VIN: begin
        if (drp_drdy) begin
          vin_raw_d = drp_do[15:4];
          state_d   = REQ_VOUT;
        end else if (tmo_q == TMO_LAST) begin
          tflag_d = 1'b1;
          poll_d  = 16'd0;
          state_d = WAIT;
`ifdef XADC_AVG_EN
          vin_sum_d  = 14'd0;
          vout_sum_d = 14'd0;
          rnd_d      = 2'd0;
`endif
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end

      REQ_VOUT: begin
        den_d   = 1'b1;
        daddr_d = VOUT_ADDR;
        tmo_d   = 8'd1;
        state_d = WAIT_VOUT;
      end

      WAIT_VOUT: begin
        if (drp_drdy) begin
          vout_raw_d = drp_do[15:4];
          state_d    = UPDATE;
        end else if (tmo_q == TMO_LAST) begin
          tflag_d = 1'b1;
          poll_d  = 16'd0;
          state_d = WAIT;
`ifdef XADC_AVG_EN
          vin_sum_d  = 14'd0;
          vout_sum_d = 14'd0;
          rnd_d      = 2'd0;
`endif
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end

      UPDATE: begin
`ifdef XADC_AVG_EN
        if (rnd_q == 2'd3) begin
          vin_d      = vin_acc[13:2];
          vout_d     = vout_acc[13:2];
          ov_d       = (vout_acc[13:2] > OV_LIMIT);
          valid_d    = 1'b1;
          vin_sum_d  = 14'd0;
          vout_sum_d = 14'd0;
          rnd_d      = 2'd0;
        end else begin
          vin_sum_d  = vin_acc;
          vout_sum_d = vout_acc;
          rnd_d      = rnd_q + 2'd1;
        end
`else
        vin_d   = vin_raw_q;
        vout_d  = vout_raw_q;
        ov_d    = (vout_raw_q > OV_LIMIT);
        valid_d = 1'b1;
`endif
        poll_d  = 16'd0;
        state_d = WAIT;
      end

      default: begin
        poll_d  = 16'd0;
        state_d = WAIT;
      end
    endcase
  end

  // State and output registers; reset abandons any in-flight DRP read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= WAIT;
      poll_q     <= 16'd0;
      tmo_q      <= 8'd0;
      den_q      <= 1'b0;
      daddr_q    <= 7'd0;
      vin_raw_q  <= 12'd0;
      vout_raw_q <= 12'd0;
      vin_q      <= 12'd0;
      vout_q     <= 12'd0;
      valid_q    <= 1'b0;
      ov_q       <= 1'b0;
      tflag_q    <= 1'b0;
`ifdef XADC_AVG_EN
      vin_sum_q  <= 14'd0;
      vout_sum_q <= 14'd0;
      rnd_q      <= 2'd0;
`endif
    end else begin
      state_q    <= state_d;
      poll_q     <= poll_d;
      tmo_q      <= tmo_d;
      den_q      <= den_d;
      daddr_q    <= daddr_d;
      vin_raw_q  <= vin_raw_d;
      vout_raw_q <= vout_raw_d;
      vin_q      <= vin_d;
      vout_q     <= vout_d;
      valid_q    <= valid_d;
      ov_q       <= ov_d;
      tflag_q    <= tflag_d;
`ifdef XADC_AVG_EN
      vin_sum_q  <= vin_sum_d;
      vout_sum_q <= vout_sum_d;
      rnd_q      <= rnd_d;
`endif
    end
  end

  assign drp_den      = den_q;
  assign drp_daddr    = daddr_q;
  assign drp_dwe      = 1'b0;
  assign vin_adc      = vin_q;
  assign vout_adc     = vout_q;
  assign sample_valid = valid_q;
  assign vout_ov      = ov_q;
  assign drp_timeout  = tflag_q;

endmodule

// File: tb/tb_xadc_monitor_sampler.sv
// tb/tb_xadc_monitor_sampler.sv - scoreboard bench for xadc_monitor_sampler with a DRP responder model
`timescale 1ns/1ps
module tb_xadc_monitor_sampler;

  localparam int          P      = 10;
  localparam logic [6:0]  VIN_A  = 7'h13;
  localparam logic [6:0]  VOUT_A = 7'h1B;
  localparam logic [11:0] OVL    = 12'd460;

  logic        clk;
  logic        rst_n;
  logic        drp_den;
  logic [6:0]  drp_daddr;
  logic        drp_dwe;
  logic        drp_drdy;
  logic [15:0] drp_do;
  logic [11:0] vin_adc;
  logic [11:0] vout_adc;
  logic        sample_valid;
  logic        vout_ov;
  logic        drp_timeout;

  xadc_monitor_sampler #(
    .VIN_ADDR (VIN_A),
    .VOUT_ADDR(VOUT_A),
    .POLL_DIV (P),
    .OV_LIMIT (OVL)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .drp_den     (drp_den),
    .drp_daddr   (drp_daddr),
    .drp_dwe     (drp_dwe),
    .drp_drdy    (drp_drdy),
    .drp_do      (drp_do),
    .vin_adc     (vin_adc),
    .vout_adc    (vout_adc),
    .sample_valid(sample_valid),
    .vout_ov     (vout_ov),
    .drp_timeout (drp_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  typedef struct packed {
    logic [11:0] vin;
    logic [11:0] vout;
    logic        ov;
  } exp_t;

  exp_t sb_q[$];
  exp_t last_exp = '0;

`ifdef XADC_AVG_EN
  int acc_n = 0;
  int acc_vin = 0;
  int acc_vout = 0;
`endif

  task automatic expect_round(input logic [15:0] vd, input logic [15:0] od);
    exp_t e;
`ifdef XADC_AVG_EN
    acc_vin  += int'(vd[15:4]);
    acc_vout += int'(od[15:4]);
    acc_n++;
    if (acc_n == 4) begin
      e.vin  = 12'(acc_vin / 4);
      e.vout = 12'(acc_vout / 4);
      e.ov   = (e.vout > OVL);
      sb_q.push_back(e);
      acc_n = 0; acc_vin = 0; acc_vout = 0;
    end
`else
    e.vin  = vd[15:4];
    e.vout = od[15:4];
    e.ov   = (od[15:4] > OVL);
    sb_q.push_back(e);
`endif
  endtask

  task automatic model_discard();
`ifdef XADC_AVG_EN
    acc_n = 0; acc_vin = 0; acc_vout = 0;
`endif
  endtask

  // DRP responder: answers each den after a per-channel latency (<=0 means never)
  logic [15:0] vin_do_v, vout_do_v;
  int          lat_vin, lat_vout;
  bit          spur_mode = 1'b0;
  int          pend;
  logic [15:0] pend_data;
  int          den_cnt = 0;
  logic [6:0]  den_addr_log[64];
  int          den_cyc_log[64];
  logic        prev_den;

  initial begin
    int lat;
    drp_drdy = 1'b0;
    drp_do   = 16'h0;
    pend     = -1;
    prev_den = 1'b0;
    forever begin
      @(negedge clk);
      drp_drdy = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          drp_drdy = 1'b1;
          drp_do   = pend_data;
          pend     = -1;
        end
      end else if (spur_mode && drp_den !== 1'b1) begin
        drp_drdy = 1'b1;
        drp_do   = 16'hFFF0;
      end
      if (drp_den === 1'b1) begin
        check("den_one_cycle", prev_den, 1'b0);
        check("one_outstanding", 32'(pend > 0), 0);
        if (den_cnt < 64) begin
          den_addr_log[den_cnt] = drp_daddr;
          den_cyc_log[den_cnt]  = cyc;
        end
        den_cnt++;
        lat       = (drp_daddr == VIN_A) ? lat_vin : lat_vout;
        pend_data = (drp_daddr == VIN_A) ? vin_do_v : vout_do_v;
        pend      = (lat > 0) ? lat : -1;
      end
      prev_den = drp_den;
    end
  end

  // Scoreboard: every sample_valid pulse must match the oldest pending expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sample_valid === 1'b1) begin
        if (sb_q.size() == 0) begin
          check("valid_unexpected", sample_valid, 1'b0);
        end else begin
          e = sb_q.pop_front();
          check("vin_adc", vin_adc, e.vin);
          check("vout_adc", vout_adc, e.vout);
          check("vout_ov", vout_ov, e.ov);
          last_exp = e;
        end
      end
    end
  end

  task automatic do_round(input logic [15:0] vd, input logic [15:0] od, input int lv, input int lo);
    int start;
    int t;
    int dc;
    start = den_cnt;
    vin_do_v = vd; vout_do_v = od; lat_vin = lv; lat_vout = lo;
    if (lv > 0 && lo > 0) expect_round(vd, od);
    t = 0;
    while (den_cnt < start + 2 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("den_pair_seen", 32'(den_cnt >= start + 2), 1);
    if (den_cnt >= start + 2) begin
      check("den_addr_vin", den_addr_log[start], VIN_A);
      check("den_addr_vout", den_addr_log[start+1], VOUT_A);
      if (lo > 0) begin
        repeat (lo + 4) @(negedge clk);
      end else begin
        dc = den_cyc_log[start+1];
        while (cyc < dc + 254) @(negedge clk);
        check("tmo_not_early", drp_timeout, 1'b0);
        @(negedge clk);
        check("tmo_at_255", drp_timeout, 1'b1);
        repeat (2) @(negedge clk);
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_den"}, drp_den, 1'b0);
    check({tag, "_daddr"}, drp_daddr, 7'd0);
    check({tag, "_vin"}, vin_adc, 12'd0);
    check({tag, "_vout"}, vout_adc, 12'd0);
    check({tag, "_valid"}, sample_valid, 1'b0);
    check({tag, "_ov"}, vout_ov, 1'b0);
    check({tag, "_tmo"}, drp_timeout, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    int rel;
    int s;
    int t;
    logic [15:0] avg_vals[4];
    rst_n = 1'b0;
    vin_do_v = 16'h0; vout_do_v = 16'h0; lat_vin = 3; lat_vout = 3;
    avg_vals[0] = 16'h0640; avg_vals[1] = 16'h0650;
    avg_vals[2] = 16'h0660; avg_vals[3] = 16'h0690;

    repeat (3) @(negedge clk);
    check_all_zero("rst");
    check("dwe_tied", drp_dwe, 1'b0);

    rel = cyc;
    rst_n = 1'b1;
    do_round(16'h2A50, 16'h1B80, 3, 3);
    check("first_den_latency", 32'(den_cyc_log[0] - rel), P + 1);

    do_round(16'h2A50, 16'h1CD0, 3, 3);
    do_round(16'h2A50, 16'h1CC0, 3, 3);

    spur_mode = 1'b1;
    s = den_cnt;
    do_round(16'h3000, 16'h1000, 3, 3);
    spur_mode = 1'b0;
    check("spur_den_gap", 32'(den_cyc_log[s] - den_cyc_log[s-1]), 3 + 3 + P);

    do_round(16'h1110, 16'h1230, 3, 254);
    check("drdy_at_limit", drp_timeout, 1'b0);

    do_round(16'h2220, 16'h1F00, 3, -1);
    model_discard();
    check("tmo_vin_kept", vin_adc, last_exp.vin);
    check("tmo_vout_kept", vout_adc, last_exp.vout);
    check("tmo_ov_kept", vout_ov, last_exp.ov);

    for (int i = 0; i < 4; i++) do_round(avg_vals[i], 16'h0C80, 3, 3);
    check("tmo_sticky", drp_timeout, 1'b1);

    s = den_cnt;
    vin_do_v = 16'h3330; vout_do_v = 16'h0400; lat_vin = 3; lat_vout = 3;
    t = 0;
    while (den_cnt == s && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("pre_reset_den", 32'(den_cnt > s), 1);
    while (cyc < den_cyc_log[s] + 1) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    model_discard();
    @(negedge clk);
    rel = cyc;
    rst_n = 1'b1;
    t = 0;
    while (den_cnt < s + 2 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("post_reset_den", 32'(den_cnt >= s + 2), 1);
    check("post_reset_latency", 32'(den_cyc_log[s+1] - rel), P + 1);
    check("post_reset_addr", den_addr_log[s+1], VIN_A);
    check("late_drdy_ignored", vin_adc, 12'd0);
    expect_round(vin_do_v, vout_do_v);
    repeat (20) @(negedge clk);
    check("sb_drained", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
